// File: rtl/led_status_driver.sv
// LED front-end: per-LED off/static/blink/PWM modes behind a PLL-lock supervisor
// that shows a bouncing scan pattern until lock has been stable for LOCK_SETTLE cycles.
module led_status_driver #(
  parameter int NUM_LEDS    = 5,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter int BLINK_DIV   = 12_500_000,
  parameter int SCAN_DIV    = 5_000_000,
  parameter int LOCK_SETTLE = 1_000_000,
  parameter int PWM_BITS    = 8
) (
  input  logic                  clk_50,
  input  logic                  global_reset,
  input  logic                  pll_locked,
  input  logic [NUM_LEDS-1:0]   pio_val,
  input  logic [2*NUM_LEDS-1:0] led_mode,
  input  logic [PWM_BITS-1:0]   brightness,
  output logic                  scanning,
  output logic [NUM_LEDS-1:0]   LED
);

  localparam int BW = $clog2(BLINK_DIV);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int SW = (LOCK_SETTLE > 1) ? $clog2(LOCK_SETTLE) : 1;
  localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [BW-1:0] BLINK_LAST  = BW'(BLINK_DIV - 1);
  localparam logic [CW-1:0] SCAN_LAST   = CW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(LOCK_SETTLE - 1);
  localparam logic [PW-1:0] POS_LAST    = PW'(NUM_LEDS - 1);
  // XOR mask that turns a logical "on" vector into pin levels.
  localparam logic [NUM_LEDS-1:0] UNLIT = ACTIVE_LOW ? {NUM_LEDS{1'b1}} : {NUM_LEDS{1'b0}};

  typedef enum logic [1:0] {
    ST_SCAN   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  state_t                state_r;
  logic                  lock_meta_r;
  logic                  lock_s;
  logic [SW-1:0]         settle_cnt_r;
  logic [CW-1:0]         scan_cnt_r;
  logic [PW-1:0]         scan_pos_r;
  logic                  scan_up_r;
  logic [BW-1:0]         blink_cnt_r;
  logic                  blink_phase_r;
  logic [PWM_BITS-1:0]   pwm_cnt_r;

  logic [CW-1:0]         scan_cnt_nx_s;
  logic [PW-1:0]         scan_pos_nx_s;
  logic                  scan_up_nx_s;
  logic                  pwm_on_s;
  logic [NUM_LEDS-1:0]   disp_s;

  // Next scan position: bounce between the end LEDs, one step per scan_cnt wrap.
  always_comb begin
    scan_cnt_nx_s = scan_cnt_r + 1'b1;
    scan_pos_nx_s = scan_pos_r;
    scan_up_nx_s  = scan_up_r;
    if (scan_cnt_r == SCAN_LAST) begin
      scan_cnt_nx_s = '0;
      if (NUM_LEDS > 1) begin
        if (scan_up_r) begin
          if (scan_pos_r == POS_LAST) begin
            scan_up_nx_s  = 1'b0;
            scan_pos_nx_s = scan_pos_r - 1'b1;
          end else begin
            scan_pos_nx_s = scan_pos_r + 1'b1;
          end
        end else begin
          if (scan_pos_r == '0) begin
            scan_up_nx_s  = 1'b1;
            scan_pos_nx_s = scan_pos_r + 1'b1;
          end else begin
            scan_pos_nx_s = scan_pos_r - 1'b1;
          end
        end
      end else begin
        scan_pos_nx_s = '0;
      end
    end else begin
      scan_cnt_nx_s = scan_cnt_r + 1'b1;
    end
  end

  // Logical LED pattern for the current state, before the output register.
  always_comb begin
    pwm_on_s = (pwm_cnt_r < brightness);
    disp_s   = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (state_r == ST_RUN) begin
        case (led_mode[2*i +: 2])
          2'b00:   disp_s[i] = 1'b0;
          2'b01:   disp_s[i] = pio_val[i];
          2'b10:   disp_s[i] = pio_val[i] & blink_phase_r;
          2'b11:   disp_s[i] = pio_val[i] & pwm_on_s;
          default: disp_s[i] = 1'b0;
        endcase
      end else begin
        disp_s[i] = (scan_pos_r == PW'(i));
      end
    end
  end

  // Lock synchroniser, supervisor FSM, display counters and registered outputs.
  always_ff @(posedge clk_50) begin
    if (global_reset) begin
      lock_meta_r   <= 1'b0;
      lock_s        <= 1'b0;
      state_r       <= ST_SCAN;
      settle_cnt_r  <= '0;
      scan_cnt_r    <= '0;
      scan_pos_r    <= '0;
      scan_up_r     <= 1'b1;
      blink_cnt_r   <= '0;
      blink_phase_r <= 1'b1;
      pwm_cnt_r     <= '0;
      scanning      <= 1'b1;
      LED           <= UNLIT;
    end else begin
      lock_meta_r <= pll_locked;
      lock_s      <= lock_meta_r;
      pwm_cnt_r   <= pwm_cnt_r + 1'b1;
      scanning    <= (state_r != ST_RUN);
      LED         <= disp_s ^ UNLIT;
      case (state_r)
        ST_SCAN: begin
          scan_cnt_r    <= scan_cnt_nx_s;
          scan_pos_r    <= scan_pos_nx_s;
          scan_up_r     <= scan_up_nx_s;
          blink_cnt_r   <= '0;
          blink_phase_r <= 1'b1;
          settle_cnt_r  <= '0;
          if (lock_s) begin
            state_r <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          scan_cnt_r    <= scan_cnt_nx_s;
          scan_pos_r    <= scan_pos_nx_s;
          scan_up_r     <= scan_up_nx_s;
          blink_cnt_r   <= '0;
          blink_phase_r <= 1'b1;
          if (!lock_s) begin
            state_r <= ST_SCAN;
          end else if (settle_cnt_r == SETTLE_LAST) begin
            state_r <= ST_RUN;
          end else begin
            settle_cnt_r <= settle_cnt_r + 1'b1;
          end
        end
        ST_RUN: begin
          // Scan state is parked so a lock loss restarts the pattern at LED 0.
          scan_cnt_r <= '0;
          scan_pos_r <= '0;
          scan_up_r  <= 1'b1;
          if (blink_cnt_r == BLINK_LAST) begin
            blink_cnt_r   <= '0;
            blink_phase_r <= ~blink_phase_r;
          end else begin
            blink_cnt_r <= blink_cnt_r + 1'b1;
          end
          if (!lock_s) begin
            state_r <= ST_SCAN;
          end
        end
        default: begin
          state_r <= ST_SCAN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_status_driver.sv
// Directed bench for led_status_driver with small dividers so every phase is reachable.
module tb_led_status_driver;

  logic       clk_50 = 1'b0;
  logic       global_reset;
  logic       pll_locked;
  logic [4:0] pio_val;
  logic [9:0] led_mode;
  logic [2:0] brightness;
  logic       scanning;
  logic [4:0] LED;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_50 = ~clk_50;

  led_status_driver #(
    .NUM_LEDS(5), .ACTIVE_LOW(1'b1), .BLINK_DIV(4),
    .SCAN_DIV(2), .LOCK_SETTLE(3), .PWM_BITS(3)
  ) dut (
    .clk_50(clk_50), .global_reset(global_reset), .pll_locked(pll_locked),
    .pio_val(pio_val), .led_mode(led_mode), .brightness(brightness),
    .scanning(scanning), .LED(LED)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  initial begin
    int seq [9] = '{0, 1, 2, 3, 4, 3, 2, 1, 0};
    int blk_exp [3] = '{3, 0, 7};
    logic [2:0] blk_val [3] = '{3'd3, 3'd0, 3'd7};
    logic [4:0] lit;
    int lows;

    global_reset = 1'b1;
    pll_locked   = 1'b0;
    pio_val      = 5'b10111;
    led_mode     = 10'b01_01_01_11_10;
    brightness   = 3'd3;
    step(2);
    check_val("reset_led", LED, 5'b11111);
    check_val("reset_scanning", scanning, 1'b1);

    // Bouncing scan: one lit LED, moving every 2 clocks.
    global_reset = 1'b0;
    step(1);
    check_val("scan_pos0", LED, 5'b11110);
    for (int k = 1; k < 9; k++) begin
      step(2);
      lit = 5'b00001 << seq[k];
      lit = ~lit;
      check_val($sformatf("scan_step%0d", k), LED, lit);
    end

    // One-cycle lock pulse reaches SETTLE and falls back to SCAN.
    pll_locked = 1'b1;
    step(1);
    pll_locked = 1'b0;
    step(10);
    check_val("glitch_scanning", scanning, 1'b1);

    // Stable lock: 2 sync + 3 settle cycles, then first RUN frame.
    pll_locked = 1'b1;
    step(6);
    check_val("settle_scanning", scanning, 1'b1);
    step(1);
    check_val("run_scanning", scanning, 1'b0);
    check_val("run_static_hi", LED[4:2], 3'b010);
    check_val("blink_k0", LED[0], 1'b0);
    for (int k = 1; k < 16; k++) begin
      step(1);
      check_val($sformatf("blink_k%0d", k), LED[0], (k / 4) % 2);
    end

    // Static mode and off mode.
    led_mode = 10'b01_01_01_01_01;
    pio_val  = 5'b10101;
    step(1);
    check_val("static_10101", LED, 5'b01010);
    pio_val = 5'b01100;
    step(1);
    check_val("static_01100", LED, 5'b10011);
    pio_val  = 5'b11111;
    led_mode = 10'b00_01_01_01_01;
    step(1);
    check_val("mode_off_led4", LED, 5'b10000);

    // PWM duty: count lit (low) cycles over a full 8-cycle period.
    led_mode = 10'b01_01_01_11_01;
    for (int b = 0; b < 3; b++) begin
      brightness = blk_val[b];
      step(1);
      lows = 0;
      for (int c = 0; c < 8; c++) begin
        step(1);
        if (LED[1] == 1'b0) lows++;
      end
      check_val($sformatf("pwm_b%0d", blk_val[b]), lows, blk_exp[b]);
    end

    // Lock loss in RUN: scan restarts at LED 0.
    led_mode   = 10'b01_01_01_01_10;
    pll_locked = 1'b0;
    step(3);
    check_val("unlock_latency", scanning, 1'b0);
    step(1);
    check_val("unlock_scanning", scanning, 1'b1);
    check_val("unlock_pos0", LED, 5'b11110);
    step(2);
    check_val("unlock_pos1", LED, 5'b11101);

    // Reset while blinking LEDs are lit.
    led_mode   = 10'b10_10_10_10_10;
    pio_val    = 5'b11111;
    pll_locked = 1'b1;
    step(7);
    check_val("relock_blink_on", LED, 5'b00000);
    check_val("relock_scanning", scanning, 1'b0);
    step(2);
    global_reset = 1'b1;
    step(1);
    check_val("midrun_reset_led", LED, 5'b11111);
    check_val("midrun_reset_scan", scanning, 1'b1);
    global_reset = 1'b0;
    step(1);
    check_val("post_reset_pos0", LED, 5'b11110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
